keypad_scanner: RTL

- Input-side counterpart of the multiplexed 7-segment display driver: time-multiplexed row scanning of a 4x4 key matrix instead of digit scanning.
- Drives one matrix row low at a time, samples the active-low columns, and debounces over whole scan frames.
- Presents one key code with press/release pulses to the piano note logic.

---
 rtl/keypad_scanner.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanned 4x4 key matrix reader.
// Drives one row low per dwell period, samples the active-low columns at the
// end of each dwell, folds four row samples into one frame result, debounces
// over whole frames, and reports a single accepted key with press/release
// pulses.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic       key_valid,
    output logic       key_release
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [3:0]    STAB_MAX   = 4'(DEBOUNCE_SCANS);

    // A frame result or stable result: vld=0 means "no key".
    typedef struct packed {
        logic       vld;
        logic [3:0] code;
    } key_t;

    localparam key_t KEY_NONE = '{vld: 1'b0, code: 4'd0};

    typedef enum logic {
        ST_IDLE,
        ST_PRESSED
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    row_out_q, row_out_d;
    key_t          cand_q, cand_d;
    logic          multi_q, multi_d;
    key_t          last_q, last_d;
    logic [3:0]    stab_q, stab_d;
    key_t          stable_q, stable_d;

    state_t        state_q;
    logic [3:0]    key_code_q;
    logic          key_held_q;
    logic          key_valid_q;
    logic          key_release_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic       tick;
    logic       frame_end;
    logic [3:0] col_low;
    logic [2:0] n_low;
    logic [1:0] col_idx;
    key_t       cand_n;
    logic       multi_n;
    key_t       frame_res;

    // Two-flop synchronizer for the asynchronous column inputs.
    always_comb begin
        sync1_d = col_in;
        sync2_d = sync1_q;
    end

    // Dwell counter and row sequencing; the row changes on the dwell tick.
    always_comb begin
        tick      = (cnt_q == DWELL_LAST);
        frame_end = tick && (row_q == 2'd3);
        cnt_d     = tick ? '0 : cnt_q + CW'(1);
        row_d     = tick ? row_q + 2'd1 : row_q;
        row_out_d = tick ? ~(4'b0001 << row_d) : row_out_q;
    end

    // Decode the synchronized columns of the row being dwelt on.
    always_comb begin
        col_low = ~sync2_q;
        n_low   = 3'($countones(col_low));
        col_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (col_low[i]) col_idx = 2'(i);
        end
    end

    // Fold each row sample into the frame accumulator; close the frame on
    // the row-3 tick. Two keys anywhere in a frame reject the whole frame,
    // which also rejects ghost patterns.
    always_comb begin
        cand_n    = cand_q;
        multi_n   = multi_q;
        frame_res = KEY_NONE;
        cand_d    = cand_q;
        multi_d   = multi_q;
        if (tick) begin
            if (n_low > 3'd1) begin
                multi_n = 1'b1;
            end else if (n_low == 3'd1) begin
                if (cand_q.vld) begin
                    multi_n = 1'b1;
                end else begin
                    cand_n = '{vld: 1'b1, code: {row_q, col_idx}};
                end
            end
            if (frame_end) begin
                frame_res = multi_n ? KEY_NONE : cand_n;
                cand_d    = KEY_NONE;
                multi_d   = 1'b0;
            end else begin
                cand_d    = cand_n;
                multi_d   = multi_n;
            end
        end
    end

    // Frame-level debounce: a result becomes stable once it has been seen
    // in STAB_MAX consecutive frames.
    always_comb begin
        last_d   = last_q;
        stab_d   = stab_q;
        stable_d = stable_q;
        if (frame_end) begin
            if (frame_res == last_q) begin
                stab_d = (stab_q >= STAB_MAX) ? STAB_MAX : stab_q + 4'd1;
            end else begin
                stab_d = 4'd1;
                last_d = frame_res;
            end
            if (stab_d == STAB_MAX) stable_d = frame_res;
        end
    end

    // Scan, accumulation and debounce registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 4'b1111;
            sync2_q   <= 4'b1111;
            cnt_q     <= '0;
            row_q     <= 2'd0;
            row_out_q <= 4'b1110;
            cand_q    <= KEY_NONE;
            multi_q   <= 1'b0;
            last_q    <= KEY_NONE;
            stab_q    <= 4'd0;
            stable_q  <= KEY_NONE;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            row_out_q <= row_out_d;
            cand_q    <= cand_d;
            multi_q   <= multi_d;
            last_q    <= last_d;
            stab_q    <= stab_d;
            stable_q  <= stable_d;
        end
    end

    // Press/release FSM reacting to the stable result one cycle after it
    // changes; pulses are cleared every cycle so they last exactly one clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            key_code_q    <= 4'd0;
            key_held_q    <= 1'b0;
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (stable_q.vld) begin
                        key_code_q  <= stable_q.code;
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                        state_q     <= ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (!stable_q.vld) begin
                        key_release_q <= 1'b1;
                        key_held_q    <= 1'b0;
                        state_q       <= ST_IDLE;
                    end else if (stable_q.code != key_code_q) begin
                        key_release_q <= 1'b1;
                        key_valid_q   <= 1'b1;
                        key_code_q    <= stable_q.code;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign row_out     = row_out_q;
    assign key_code    = key_code_q;
    assign key_held    = key_held_q;
    assign key_valid   = key_valid_q;
    assign key_release = key_release_q;

endmodule
